mem_arbiter: RTL and testbench

- Two-port round-robin arbiter in front of the single-port `mem` block (valid/ready, wr_rd, addr, wdata, rdata).
- Two requesters share the memory. The arbiter grants one, registers its request onto the memory bus, and waits for the memory's `ready`.
- It then returns a one-cycle response pulse (with read data) to the winner.
- A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// Registers the winning request onto the memory bus and returns a one-cycle response.
module mem_arbiter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  r0_valid,
  input  logic                  r0_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]      r0_wdata,
  output logic                  r0_ready,
  output logic [WIDTH-1:0]      r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_valid,
  input  logic                  r1_wr_rd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]      r1_wdata,
  output logic                  r1_ready,
  output logic [WIDTH-1:0]      r1_rdata,
  output logic                  r1_err,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  gnt_q, gnt_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  mv_q, mv_d;
  logic                  mwr_q, mwr_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [WIDTH-1:0]      mwdata_q, mwdata_d;
  logic [1:0]            rdy_q, rdy_d;
  logic [1:0]            err_q, err_d;
  logic [WIDTH-1:0]      rd0_q, rd0_d;
  logic [WIDTH-1:0]      rd1_q, rd1_d;
  logic                  win;
  logic                  timeout;

  // The pointer only decides when both ports contend.
  assign win = (r0_valid && r1_valid) ? ptr_q : r1_valid;

  // The wait counter holds the cycles already spent in BUSY.
  assign timeout = (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    wd_d     = wd_q;
    mv_d     = mv_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdy_d    = '0;
    err_d    = '0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    unique case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          gnt_d    = win;
          mv_d     = 1'b1;
          mwr_d    = win ? r1_wr_rd : r0_wr_rd;
          maddr_d  = win ? r1_addr : r0_addr;
          mwdata_d = win ? r1_wdata : r0_wdata;
          wd_d     = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          mv_d         = 1'b0;
          rdy_d[gnt_q] = 1'b1;
          if (!mwr_q) begin
            if (gnt_q) rd1_d = m_rdata;
            else       rd0_d = m_rdata;
          end
          ptr_d   = ~gnt_q;
          state_d = DONE;
        end else if (timeout) begin
          mv_d         = 1'b0;
          rdy_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          ptr_d        = ~gnt_q;
          state_d      = DONE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      wd_q     <= '0;
      mv_q     <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdy_q    <= '0;
      err_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wd_q     <= wd_d;
      mv_q     <= mv_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign m_valid  = mv_q;
  assign m_wr_rd  = mwr_q;
  assign m_addr   = maddr_q;
  assign m_wdata  = mwdata_q;
  assign r0_ready = rdy_q[0];
  assign r1_ready = rdy_q[1];
  assign r0_err   = err_q[0];
  assign r1_err   = err_q[1];
  assign r0_rdata = rd0_q;
  assign r1_rdata = rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requesters, a memory responder and a
// transaction-timestamp reference model compared every cycle.
module tb_mem_arbiter;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             res;
  logic             r0_valid, r0_wr_rd, r0_ready, r0_err;
  logic [AW-1:0]    r0_addr;
  logic [WIDTH-1:0] r0_wdata, r0_rdata;
  logic             r1_valid, r1_wr_rd, r1_ready, r1_err;
  logic [AW-1:0]    r1_addr;
  logic [WIDTH-1:0] r1_wdata, r1_rdata;
  logic             m_valid, m_wr_rd, m_ready;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .res(res),
    .r0_valid(r0_valid), .r0_wr_rd(r0_wr_rd), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_wr_rd(r1_wr_rd), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .r1_err(r1_err),
    .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct packed {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } req_t;

  typedef struct {
    int               port;
    logic             err;
    logic [WIDTH-1:0] rdata;
    int               run;
  } cpl_t;

  req_t q0[$];
  req_t q1[$];
  cpl_t clog[$];
  req_t alog[$];
  int   glog[$];

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sb  [DEPTH];
  bit               sb_ok [DEPTH];

  int never_n = 0;
  int lat_max = 1;
  bit mixed   = 0;
  int mw = 0;
  int md = 0;
  int mv_cnt = 0;
  int lo_cnt = 1000;

  // Reference model: one open transaction at a time, described by the
  // edge index of its grant and of its completion.
  int               n = 0;
  bit               m_open = 0;
  int               t_grant = 0;
  int               t_end = -100;
  int               pref = 0;
  int               mg = 0;
  bit               e_to = 0;
  req_t             cur = '0;
  logic [WIDTH-1:0] e_rd [2];

  always @(posedge clk) begin
    n++;
    if (res) begin
      m_open = 0;
      t_end  = -100;
      pref   = 0;
      e_to   = 0;
      cur    = '0;
      e_rd[0] = '0;
      e_rd[1] = '0;
    end else if (m_open) begin
      if (m_ready || (n - t_grant) == TIMEOUT) begin
        m_open = 0;
        t_end  = n;
        e_to   = !m_ready;
        if (m_ready && !cur.wr) e_rd[mg] = m_rdata;
        pref = 1 - mg;
      end
    end else if (n >= t_end + 2 && (r0_valid || r1_valid)) begin
      if (r0_valid && r1_valid) mg = pref;
      else mg = r1_valid ? 1 : 0;
      cur = (mg == 1) ? {r1_wr_rd, r1_addr, r1_wdata}
                      : {r0_wr_rd, r0_addr, r0_wdata};
      m_open  = 1;
      t_grant = n;
      glog.push_back(mg);
    end
  end

  logic [34:0] act, expv;
  always @(negedge clk) begin
    if (n > 0) begin
      act = {m_valid, m_wr_rd, m_addr, m_wdata,
             r0_ready, r0_err, r0_rdata, r1_ready, r1_err, r1_rdata};
      expv = {m_open, cur.wr, cur.addr, cur.data,
              (n == t_end && mg == 0), (n == t_end && mg == 0 && e_to), e_rd[0],
              (n == t_end && mg == 1), (n == t_end && mg == 1 && e_to), e_rd[1]};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h expected %h", n, act, expv);
      end
    end
  end

  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cpl(input int p, input logic er, input logic [WIDTH-1:0] rd);
    req_t h;
    cpl_t c;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL spurious_ready: port %0d got ready expected none", p);
      return;
    end
    h = (p == 0) ? q0.pop_front() : q1.pop_front();
    c.port = p;
    c.err = er;
    c.rdata = rd;
    c.run = mv_cnt;
    clog.push_back(c);
    if (!er) begin
      if (h.wr) begin
        sb[h.addr] = h.data;
        sb_ok[h.addr] = 1;
      end else if (sb_ok[h.addr]) begin
        chk($sformatf("read_data p%0d a%0d", p, h.addr), rd, sb[h.addr]);
      end
    end
  endtask

  // Requesters and memory responder, driven away from the active edge.
  always @(negedge clk) begin
    if (r0_ready === 1'b1) cpl(0, r0_err, r0_rdata);
    if (r1_ready === 1'b1) cpl(1, r1_err, r1_rdata);
    if (m_valid === 1'b1) begin
      if (mv_cnt == 0) begin
        chk("gap_between_grants", (lo_cnt >= 1), 1);
        alog.push_back({m_wr_rd, m_addr, m_wdata});
      end
      mv_cnt++;
      lo_cnt = 0;
    end else begin
      mv_cnt = 0;
      lo_cnt++;
    end
    r0_valid = (q0.size() != 0);
    if (q0.size() != 0) {r0_wr_rd, r0_addr, r0_wdata} = q0[0];
    else {r0_wr_rd, r0_addr, r0_wdata} = 14'($urandom);
    r1_valid = (q1.size() != 0);
    if (q1.size() != 0) {r1_wr_rd, r1_addr, r1_wdata} = q1[0];
    else {r1_wr_rd, r1_addr, r1_wdata} = 14'($urandom);
    if (m_valid === 1'b1) begin
      mw++;
      if (mw == 1) begin
        if (never_n > 0) md = 0;
        else if (mixed) begin
          case ($urandom_range(0, 11))
            0: md = 0;
            1: md = TIMEOUT;
            default: md = $urandom_range(1, 4);
          endcase
        end else md = $urandom_range(1, lat_max);
      end
      m_rdata = WIDTH'($urandom);
      m_ready = 1'b0;
      if (md != 0 && mw == md) begin
        m_ready = 1'b1;
        if (m_wr_rd) mem[m_addr] = m_wdata;
        else m_rdata = mem[m_addr];
      end
    end else begin
      if (mw > 0 && md == 0 && never_n > 0) never_n--;
      mw = 0;
      m_ready = 1'b0;
      m_rdata = WIDTH'($urandom);
    end
  end

  task automatic wait_idle(input int maxc, input string nm);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_open) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_finished_in_time"}, (c < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    clog.delete();
    alog.delete();
    glog.delete();
  endtask

  initial begin
    req_t r;
    int   pushed;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      sb[i] = '0;
      sb_ok[i] = 0;
    end
    res = 1'b1;
    m_ready = 1'b0;
    m_rdata = '0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // r0 writes A5 to address 5 with a one-cycle memory
    clear_logs();
    lat_max = 1;
    @(posedge clk);
    q0.push_back('{wr: 1'b1, addr: 5'd5, data: 8'hA5});
    wait_idle(50, "t1");
    chk("t1_cpl_count", clog.size(), 1);
    if (clog.size() >= 1) begin
      chk("t1_port", clog[0].port, 0);
      chk("t1_err", clog[0].err, 0);
      chk("t1_mvalid_cycles", clog[0].run, 1);
    end
    if (alog.size() >= 1) begin
      chk("t1_m_addr", alog[0].addr, 5);
      chk("t1_m_wdata", alog[0].data, 8'hA5);
      chk("t1_m_wr", alog[0].wr, 1);
    end

    // r1 reads it back
    clear_logs();
    @(posedge clk);
    q1.push_back('{wr: 1'b0, addr: 5'd5, data: 8'h3C});
    wait_idle(50, "t2");
    chk("t2_cpl_count", clog.size(), 1);
    if (clog.size() >= 1) begin
      chk("t2_port", clog[0].port, 1);
      chk("t2_rdata", clog[0].rdata, 8'hA5);
    end

    // both ports contend for four writes each
    clear_logs();
    lat_max = 3;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{wr: 1'b1, addr: AW'(i), data: WIDTH'($urandom)});
      q1.push_back('{wr: 1'b1, addr: AW'(i), data: WIDTH'($urandom)});
    end
    wait_idle(200, "t3");
    chk("t3_cpl_count", clog.size(), 8);
    for (int i = 0; i < 8 && i < clog.size(); i++)
      chk($sformatf("t3_order_%0d", i), clog[i].port, i % 2);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("t3_model_grant_%0d", i), glog[i], i % 2);

    // watchdog: r0 never acknowledged, r1 waiting behind it
    clear_logs();
    never_n = 1;
    @(posedge clk);
    q0.push_back('{wr: 1'b1, addr: 5'd7, data: 8'h11});
    q1.push_back('{wr: 1'b0, addr: 5'd7, data: 8'h22});
    wait_idle(200, "t4");
    chk("t4_cpl_count", clog.size(), 2);
    if (clog.size() >= 2) begin
      chk("t4_first_port", clog[0].port, 0);
      chk("t4_first_err", clog[0].err, 1);
      chk("t4_mvalid_cycles", clog[0].run, TIMEOUT);
      chk("t4_second_port", clog[1].port, 1);
      chk("t4_second_err", clog[1].err, 0);
    end

    // reset while serving r1; pointer must return to port 0
    lat_max = 2;
    @(posedge clk);
    q0.push_back('{wr: 1'b1, addr: 5'd9, data: 8'h5A});
    wait_idle(50, "t5a");
    clear_logs();
    never_n = 1;
    @(posedge clk);
    q1.push_back('{wr: 1'b0, addr: 5'd9, data: 8'h00});
    begin
      int c = 0;
      while (m_valid !== 1'b1 && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("t5_grant_seen", (c < 20), 1);
    end
    repeat (3) @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    q0.push_back('{wr: 1'b1, addr: 5'd10, data: 8'h77});
    @(negedge clk);
    res = 1'b0;
    chk("t5_mvalid_after_reset", m_valid, 0);
    chk("t5_no_pulse", clog.size(), 0);
    wait_idle(200, "t5");
    chk("t5_cpl_count", clog.size(), 2);
    if (clog.size() >= 2) begin
      chk("t5_first_port", clog[0].port, 0);
      chk("t5_second_port", clog[1].port, 1);
      chk("t5_read_back", clog[1].rdata, 8'h5A);
    end

    // full sweep: fill the memory, then read it back from both ports
    clear_logs();
    lat_max = 4;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++)
      q0.push_back('{wr: 1'b1, addr: AW'(i), data: WIDTH'($urandom)});
    wait_idle(DEPTH * 40, "t6w");
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      q1.push_back('{wr: 1'b0, addr: AW'(i), data: WIDTH'($urandom)});
      q0.push_back('{wr: 1'b0, addr: AW'($urandom), data: WIDTH'($urandom)});
    end
    wait_idle(DEPTH * 80, "t6r");
    chk("t6_cpl_count", clog.size(), 3 * DEPTH);

    // random traffic with mixed latencies, timeouts and late acknowledges
    clear_logs();
    mixed = 1;
    pushed = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) begin
        r = req_t'($urandom);
        q0.push_back(r);
        pushed++;
      end
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) begin
        r = req_t'($urandom);
        q1.push_back(r);
        pushed++;
      end
    end
    wait_idle(400, "t7");
    chk("t7_cpl_count", clog.size(), pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
